// File: rtl/uarttx.sv
// UART transmitter: 1 start, 8 data LSB first, 1 parity, 1 stop; OVERSAMPLE clocks per bit.
// One-byte holding register ahead of the shift engine; tx/busy/txdone are registered.
module uarttx #(
  parameter logic PARITYMODE = 1'b0,
  parameter int   OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       txdone
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          hold_full, hold_full_n;
  logic [7:0]    hold_dat, hold_dat_n;
  logic          tx_n, busy_n, done_n;
  logic          load, bit_end;

  assign ready = ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      par       <= 1'b0;
      hold_full <= 1'b0;
      hold_dat  <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      txdone    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      par       <= par_n;
      hold_full <= hold_full_n;
      hold_dat  <= hold_dat_n;
      tx        <= tx_n;
      busy      <= busy_n;
      txdone    <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    par_n       = par;
    load        = 1'b0;
    done_n      = 1'b0;
    hold_full_n = hold_full;
    hold_dat_n  = hold_dat;
    tx_n        = 1'b1;
    bit_end     = (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        load  = hold_full;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == 3'd7) state_n = PARITY;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          // A pending byte chains straight into the next start bit.
          if (hold_full) load = 1'b1;
          else           state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Parity is frozen at load so later writes cannot disturb the frame in flight.
    if (load) begin
      state_n = START;
      cnt_n   = '0;
      idx_n   = '0;
      shift_n = hold_dat;
      par_n   = (^hold_dat) ^ PARITYMODE;
    end

    if (load) begin
      hold_full_n = 1'b0;
    end else if (wrsig && !hold_full) begin
      hold_full_n = 1'b1;
      hold_dat_n  = datain;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
